text_console: RTL and testbench

Character-stream front end for the LCD text display. It accepts bytes from the CPU side over a valid/ready handshake and keeps a cursor. It interprets a small set of control codes and writes glyph codes into the text-mode VRAM (BSRAM) that the `lcd` character renderer reads. It sits directly upstream of `lcd`, in the `PixelClk` domain, on the VRAM write port.

---
 rtl/console_pkg.sv | 19 +
 rtl/console_fill.sv | 44 ++++
 rtl/text_console.sv | 151 +++++++++++++++
 tb/tb_text_console.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared constants, control codes and FSM state type for the text console.
package console_pkg;

    localparam int unsigned COLS_DEF = 60;
    localparam int unsigned ROWS_DEF = 17;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [1:0] {
        CLEAR_ALL  = 2'd0,
        IDLE       = 2'd1,
        CLEAR_LINE = 2'd2
    } console_state_t;

endpackage

// File: rtl/console_fill.sv
// Counter-based space-fill engine: one write strobe per cycle over len_m1_i+1
// consecutive addresses starting at base_i.
module console_fill #(
    parameter int unsigned AW = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [AW-1:0] base_i,
    input  logic [AW-1:0] len_m1_i,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic          done_c
);

    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] rem_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            rem_q  <= '0;
        end else if (start_i) begin
            we_q   <= 1'b1;
            addr_q <= base_i;
            rem_q  <= len_m1_i;
        end else if (we_q) begin
            if (rem_q == '0) begin
                we_q <= 1'b0;
            end else begin
                addr_q <= addr_q + AW'(1);
                rem_q  <= rem_q - AW'(1);
            end
        end
    end

    assign we_o   = we_q;
    assign addr_o = addr_q;
    // High during the final write so the owner can leave its clear state on time.
    assign done_c = we_q && (rem_q == '0);

endmodule

// File: rtl/text_console.sv
// Character-stream front end for the LCD text VRAM: cursor, control codes and clears.
// Optional CONSOLE_AUTOWRAP_EN: a printable in the last column triggers a newline.
module text_console
    import console_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEF,
    parameter int unsigned ROWS = ROWS_DEF,
    parameter int unsigned AW   = 10
) (
    input  logic          PixelClk,
    input  logic          RST,
    input  logic          In_Valid,
    output logic          In_Ready,
    input  logic [7:0]    In_Char,
    output logic          Vram_We,
    output logic [AW-1:0] Vram_Addr,
    output logic [7:0]    Vram_Data,
    output logic [5:0]    Cursor_Col,
    output logic [4:0]    Cursor_Row,
    output logic          Busy
);

    localparam logic [5:0]    COL_LAST = 6'(COLS - 1);
    localparam logic [4:0]    ROW_LAST = 5'(ROWS - 1);
    localparam logic [AW-1:0] ALL_M1   = AW'(COLS * ROWS - 1);
    localparam logic [AW-1:0] LINE_M1  = AW'(COLS - 1);

    console_state_t state_q, state_d;
    logic [5:0]     col_q, col_d;
    logic [4:0]     row_q, row_d;
    logic [AW-1:0]  rowbase_q, rowbase_d;
    logic           pr_we_q, pr_we_d;
    logic [AW-1:0]  pr_addr_q, pr_addr_d;
    logic [7:0]     pr_data_q, pr_data_d;
    logic           ready_q, busy_q;

    logic           accept;
    logic           newline;
    logic           fill_start_c;
    logic [AW-1:0]  fill_base;
    logic [AW-1:0]  fill_len_m1;
    logic           fill_we;
    logic [AW-1:0]  fill_addr;
    logic           fill_done;

    assign accept = In_Valid && ready_q;

    // Byte interpretation, cursor movement and clear sequencing.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        rowbase_d = rowbase_q;
        pr_we_d   = 1'b0;
        pr_addr_d = pr_addr_q;
        pr_data_d = pr_data_q;
        newline   = 1'b0;
        case (state_q)
            CLEAR_ALL, CLEAR_LINE: begin
                if (fill_done) state_d = IDLE;
            end
            IDLE: begin
                if (accept) begin
                    if ((In_Char >= 8'h20) && (In_Char <= 8'h7E)) begin
                        pr_we_d   = 1'b1;
                        pr_addr_d = rowbase_q + AW'(col_q);
                        pr_data_d = In_Char;
                        if (col_q != COL_LAST) begin
                            col_d = col_q + 6'd1;
                        end
`ifdef CONSOLE_AUTOWRAP_EN
                        else begin
                            newline = 1'b1;
                            state_d = CLEAR_LINE;
                        end
`endif
                    end else if (In_Char == CH_CR) begin
                        col_d = '0;
                    end else if (In_Char == CH_LF) begin
                        newline = 1'b1;
                        state_d = CLEAR_LINE;
                    end else if (In_Char == CH_BS) begin
                        if (col_q != '0) col_d = col_q - 6'd1;
                    end else if (In_Char == CH_FF) begin
                        state_d   = CLEAR_ALL;
                        col_d     = '0;
                        row_d     = '0;
                        rowbase_d = '0;
                    end
                end
            end
            default: state_d = CLEAR_ALL;
        endcase
        if (newline) begin
            col_d     = '0;
            row_d     = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
            rowbase_d = (row_q == ROW_LAST) ? '0 : rowbase_q + AW'(COLS);
        end
    end

    // LF/FF start the fill at acceptance; reset and autowrap start it one cycle later.
    assign fill_start_c = ((state_q != IDLE) && !fill_we) ||
                          (accept && ((In_Char == CH_LF) || (In_Char == CH_FF)));
    assign fill_base    = (state_d == CLEAR_ALL) ? '0 : rowbase_d;
    assign fill_len_m1  = (state_d == CLEAR_ALL) ? ALL_M1 : LINE_M1;

    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            state_q   <= CLEAR_ALL;
            col_q     <= '0;
            row_q     <= '0;
            rowbase_q <= '0;
            pr_we_q   <= 1'b0;
            pr_addr_q <= '0;
            pr_data_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            rowbase_q <= rowbase_d;
            pr_we_q   <= pr_we_d;
            pr_addr_q <= pr_addr_d;
            pr_data_q <= pr_data_d;
            ready_q   <= (state_d == IDLE);
            busy_q    <= (state_d != IDLE);
        end
    end

    console_fill #(.AW(AW)) u_fill (
        .clk_i    (PixelClk),
        .rst_i    (RST),
        .start_i  (fill_start_c),
        .base_i   (fill_base),
        .len_m1_i (fill_len_m1),
        .we_o     (fill_we),
        .addr_o   (fill_addr),
        .done_c   (fill_done)
    );

    // Fill writes and printable writes never overlap in the same cycle.
    assign Vram_We    = fill_we | pr_we_q;
    assign Vram_Addr  = fill_we ? fill_addr : pr_addr_q;
    assign Vram_Data  = fill_we ? CH_SPACE : pr_data_q;
    assign In_Ready   = ready_q;
    assign Busy       = busy_q;
    assign Cursor_Col = col_q;
    assign Cursor_Row = row_q;

endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: directed timing steps plus a random byte
// stream checked against a cell-array/cursor reference model.
module tb_text_console;

    localparam int COLS  = 60;
    localparam int ROWS  = 17;
    localparam int CELLS = COLS * ROWS;
    localparam int LIM   = 5000;
`ifdef CONSOLE_AUTOWRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       PixelClk = 1'b0;
    logic       RST      = 1'b1;
    logic       In_Valid = 1'b0;
    logic [7:0] In_Char  = 8'h00;
    logic       In_Ready;
    logic       Vram_We;
    logic [9:0] Vram_Addr;
    logic [7:0] Vram_Data;
    logic [5:0] Cursor_Col;
    logic [4:0] Cursor_Row;
    logic       Busy;

    text_console dut (
        .PixelClk   (PixelClk),
        .RST        (RST),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .In_Char    (In_Char),
        .Vram_We    (Vram_We),
        .Vram_Addr  (Vram_Addr),
        .Vram_Data  (Vram_Data),
        .Cursor_Col (Cursor_Col),
        .Cursor_Row (Cursor_Row),
        .Busy       (Busy)
    );

    always #5 PixelClk = ~PixelClk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_mem [CELLS];
    logic [7:0] dut_mem [1024];
    int         mcol = 0;
    int         mrow = 0;

    // Shadow of what the DUT has written into VRAM.
    always @(posedge PixelClk) begin
        if (Vram_We === 1'b1) dut_mem[Vram_Addr] = Vram_Data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
        end
    endtask

    task automatic model_newline();
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
        for (int i = 0; i < COLS; i++) exp_mem[mrow * COLS + i] = 8'h20;
    endtask

    task automatic model_byte(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            exp_mem[mrow * COLS + mcol] = c;
            if (mcol < COLS - 1) mcol++;
            else if (WRAP) model_newline();
        end else if (c == 8'h0D) begin
            mcol = 0;
        end else if (c == 8'h0A) begin
            model_newline();
        end else if (c == 8'h08) begin
            if (mcol > 0) mcol--;
        end else if (c == 8'h0C) begin
            for (int i = 0; i < CELLS; i++) exp_mem[i] = 8'h20;
            mcol = 0;
            mrow = 0;
        end
    endtask

    // Present one byte; returns at the falling edge of the cycle after acceptance.
    task automatic send(input logic [7:0] c);
        int n = 0;
        In_Valid = 1'b1;
        In_Char  = c;
        while (In_Ready !== 1'b1 && n < LIM) begin
            @(negedge PixelClk);
            n++;
        end
        if (n >= LIM) chk("send_timeout", 32'(n), 32'(0));
        @(negedge PixelClk);
        In_Valid = 1'b0;
        In_Char  = 8'h00;
        model_byte(c);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (In_Ready !== 1'b1 && n < LIM) begin
            @(negedge PixelClk);
            n++;
        end
        chk("ready", 32'(In_Ready), 32'(1));
    endtask

    // Walk a clear from the current cycle, checking address order, data and Busy.
    task automatic wait_clear(input int base, output int writes, output int cycles, output int bad);
        writes = 0;
        cycles = 0;
        bad    = 0;
        while (In_Ready !== 1'b1 && cycles < LIM) begin
            cycles++;
            if (Busy !== 1'b1) bad++;
            if (Vram_We === 1'b1) begin
                if (Vram_Addr !== 10'(base + writes) || Vram_Data !== 8'h20) bad++;
                writes++;
            end
            @(negedge PixelClk);
        end
    endtask

    task automatic mem_cmp(input string tag);
        int bad = 0;
        @(negedge PixelClk);
        for (int i = 0; i < CELLS; i++) if (dut_mem[i] !== exp_mem[i]) bad++;
        chk(tag, 32'(bad), 32'(0));
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_col"}, 32'(Cursor_Col), 32'(mcol));
        chk({tag, "_row"}, 32'(Cursor_Row), 32'(mrow));
    endtask

    function automatic logic [7:0] rnd_print();
        return 8'($urandom_range(32, 126));
    endfunction

    initial begin
        int w, c, b, r, n;
        logic [7:0] ch;

        for (int i = 0; i < CELLS; i++) exp_mem[i] = 8'h20;

        // Reset values
        repeat (3) @(negedge PixelClk);
        chk("rst_ready", 32'(In_Ready), 32'(0));
        chk("rst_busy",  32'(Busy), 32'(1));
        chk("rst_we",    32'(Vram_We), 32'(0));
        chk("rst_addr",  32'(Vram_Addr), 32'(0));
        chk("rst_data",  32'(Vram_Data), 32'(0));
        chk("rst_col",   32'(Cursor_Col), 32'(0));
        chk("rst_row",   32'(Cursor_Row), 32'(0));

        // Boot clear: 1020 writes of space from the first clock after release
        RST = 1'b0;
        @(negedge PixelClk);
        wait_clear(0, w, c, b);
        chk("boot_writes", 32'(w), 32'(CELLS));
        chk("boot_cycles", 32'(c), 32'(CELLS));
        chk("boot_seq",    32'(b), 32'(0));
        chk("boot_ready",  32'(In_Ready), 32'(1));
        chk_cursor("boot");
        mem_cmp("boot_mem");

        // 'A','B' back to back
        In_Valid = 1'b1;
        In_Char  = 8'h41;
        @(negedge PixelClk);
        chk("a_we",    32'(Vram_We), 32'(1));
        chk("a_addr",  32'(Vram_Addr), 32'(0));
        chk("a_data",  32'(Vram_Data), 32'(8'h41));
        chk("a_col",   32'(Cursor_Col), 32'(1));
        chk("a_ready", 32'(In_Ready), 32'(1));
        In_Char = 8'h42;
        @(negedge PixelClk);
        chk("b_we",    32'(Vram_We), 32'(1));
        chk("b_addr",  32'(Vram_Addr), 32'(1));
        chk("b_data",  32'(Vram_Data), 32'(8'h42));
        chk("b_col",   32'(Cursor_Col), 32'(2));
        chk("b_ready", 32'(In_Ready), 32'(1));
        In_Valid = 1'b0;
        model_byte(8'h41);
        model_byte(8'h42);
        @(negedge PixelClk);
        chk("ab_idle_we", 32'(Vram_We), 32'(0));

        // CR at column 7
        repeat (5) send(rnd_print());
        chk("pre_cr_col", 32'(Cursor_Col), 32'(7));
        send(8'h0D);
        chk("cr_col", 32'(Cursor_Col), 32'(0));
        chk("cr_we",  32'(Vram_We), 32'(0));

        // BS at column 0
        send(8'h08);
        chk("bs0_col", 32'(Cursor_Col), 32'(0));
        chk("bs0_row", 32'(Cursor_Row), 32'(0));
        chk("bs0_we",  32'(Vram_We), 32'(0));

        // Unknown control byte
        repeat (3) send(rnd_print());
        send(8'h07);
        chk("bel_col", 32'(Cursor_Col), 32'(3));
        chk("bel_we",  32'(Vram_We), 32'(0));
        mem_cmp("ctl_mem");

        // LF from (16,5) wraps to the top row
        send(8'h0D);
        for (int i = 0; i < ROWS - 1; i++) begin
            send(8'h0A);
            wait_ready();
        end
        repeat (5) send(rnd_print());
        chk("pre_lf_row", 32'(Cursor_Row), 32'(16));
        chk("pre_lf_col", 32'(Cursor_Col), 32'(5));
        send(8'h0A);
        chk("lf_row",   32'(Cursor_Row), 32'(0));
        chk("lf_col",   32'(Cursor_Col), 32'(0));
        chk("lf_ready", 32'(In_Ready), 32'(0));
        wait_clear(0, w, c, b);
        chk("lf_writes", 32'(w), 32'(COLS));
        chk("lf_cycles", 32'(c), 32'(COLS));
        chk("lf_seq",    32'(b), 32'(0));
        mem_cmp("lf_mem");

        // 60 printables from (0,0), then one more
        for (int i = 0; i < COLS; i++) send(rnd_print());
        wait_ready();
        chk("full_col", 32'(Cursor_Col), WRAP ? 32'(0) : 32'(COLS - 1));
        chk("full_row", 32'(Cursor_Row), WRAP ? 32'(1) : 32'(0));
        chk_cursor("full");
        mem_cmp("full_mem");
        send(rnd_print());
        wait_ready();
        chk_cursor("extra");
        mem_cmp("extra_mem");

        // Random byte stream against the model
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      ch = rnd_print();
            else if (r < 78) ch = 8'h0D;
            else if (r < 86) ch = 8'h0A;
            else if (r < 94) ch = 8'h08;
            else begin
                ch = 8'($urandom_range(0, 255));
                if ((ch >= 8'h20 && ch <= 8'h7E) || ch == 8'h0C) ch = 8'h1B;
            end
            send(ch);
            wait_ready();
            chk_cursor("rnd");
        end
        mem_cmp("rnd_mem");

        // FF from (3,10)
        send(8'h0D);
        wait_ready();
        n = 0;
        while (mrow != 3 && n < 2 * ROWS) begin
            send(8'h0A);
            wait_ready();
            n++;
        end
        repeat (10) send(rnd_print());
        chk("pre_ff_row", 32'(Cursor_Row), 32'(3));
        chk("pre_ff_col", 32'(Cursor_Col), 32'(10));
        send(8'h0C);
        wait_clear(0, w, c, b);
        chk("ff_writes", 32'(w), 32'(CELLS));
        chk("ff_cycles", 32'(c), 32'(CELLS));
        chk("ff_seq",    32'(b), 32'(0));
        chk_cursor("ff");
        mem_cmp("ff_mem");

        // Reset during the 400th write of a full clear
        send(8'h0C);
        w = 0;
        n = 0;
        while (n < LIM) begin
            if (Vram_We === 1'b1) w++;
            if (w == 400) break;
            @(negedge PixelClk);
            n++;
        end
        chk("mid_addr", 32'(Vram_Addr), 32'(399));
        RST = 1'b1;
        #1;
        chk("mid_rst_we",    32'(Vram_We), 32'(0));
        chk("mid_rst_addr",  32'(Vram_Addr), 32'(0));
        chk("mid_rst_data",  32'(Vram_Data), 32'(0));
        chk("mid_rst_ready", 32'(In_Ready), 32'(0));
        chk("mid_rst_busy",  32'(Busy), 32'(1));
        chk("mid_rst_col",   32'(Cursor_Col), 32'(0));
        chk("mid_rst_row",   32'(Cursor_Row), 32'(0));
        @(negedge PixelClk);
        RST = 1'b0;
        @(negedge PixelClk);
        wait_clear(0, w, c, b);
        chk("restart_writes", 32'(w), 32'(CELLS));
        chk("restart_cycles", 32'(c), 32'(CELLS));
        chk("restart_seq",    32'(b), 32'(0));
        chk_cursor("restart");
        mem_cmp("restart_mem");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
